// File: rtl/cm150_demux.sv
// cm150_demux: receive side of a CM150 16:1 selector link.
// Rebuilds the source bits carried on the active-low serial line into a
// registered parallel word, either addressed per beat or auto-sequenced.
// Define CM150_DEMUX_PARITY_EN to add an even-parity beat to each auto frame
// and a frame_err output; chan then carries one extra bit.
module cm150_demux #(
  parameter int unsigned           SEL_W    = 4,
  parameter logic [(2**SEL_W)-1:0] RST_WORD = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    din_n,
  input  logic                    dis,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode_auto,
  input  logic                    sync_clr,
  output logic [(2**SEL_W)-1:0]   dout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    wr_ack,
`ifdef CM150_DEMUX_PARITY_EN
  output logic                    frame_err,
  output logic [SEL_W:0]          chan
`else
  output logic [SEL_W-1:0]        chan
`endif
);

  localparam int unsigned N = 2**SEL_W;
`ifdef CM150_DEMUX_PARITY_EN
  localparam int unsigned CW = SEL_W + 1;
  localparam logic [CW-1:0] LAST = CW'(N);      // parity beat index
`else
  localparam int unsigned CW = SEL_W;
  localparam logic [CW-1:0] LAST = CW'(N - 1);  // final data beat index
`endif

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FULL} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  chan_q, chan_d;
  logic [N-1:0]   shadow_q, shadow_d;
  logic [N-1:0]   dout_q, dout_d;
  logic           out_valid_q, out_valid_d;
  logic           wr_ack_q, wr_ack_d;
  logic           mode_q, mode_d;
`ifdef CM150_DEMUX_PARITY_EN
  logic           frame_err_q, frame_err_d;
`endif

  logic           bit_c;
  logic           last_c;
  logic           blocked_c;
  logic           rdy_c;

  // State, buffers and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      chan_q      <= '0;
      shadow_q    <= RST_WORD;
      dout_q      <= RST_WORD;
      out_valid_q <= 1'b0;
      wr_ack_q    <= 1'b0;
      mode_q      <= 1'b0;
`ifdef CM150_DEMUX_PARITY_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      shadow_q    <= shadow_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      wr_ack_q    <= wr_ack_d;
      mode_q      <= mode_d;
`ifdef CM150_DEMUX_PARITY_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  // Beat acceptance, frame assembly and output handshake.
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    shadow_d    = shadow_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    wr_ack_d    = 1'b0;
    mode_d      = mode_q;
`ifdef CM150_DEMUX_PARITY_EN
    frame_err_d = frame_err_q;
`endif
    rdy_c       = 1'b0;
    bit_c       = ~din_n;
    last_c      = (chan_q == LAST);
    // Final beat cannot land while the previous frame is still unconsumed.
    blocked_c   = (state_q == S_COLLECT) && last_c && out_valid_q && !out_ready;

    if (sync_clr) begin
      chan_d   = '0;
      shadow_d = RST_WORD;
      state_d  = S_IDLE;
      mode_d   = mode_auto;
    end else if (dis) begin
      rdy_c = 1'b1;
    end else if (mode_auto != mode_q) begin
      chan_d   = '0;
      shadow_d = RST_WORD;
      state_d  = S_IDLE;
      mode_d   = mode_auto;
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (!mode_auto) begin
        rdy_c = 1'b1;
        if (in_valid) begin
          dout_d[sel] = bit_c;
          wr_ack_d    = 1'b1;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            rdy_c = 1'b1;
            if (in_valid) begin
              shadow_d[0] = bit_c;
              chan_d      = CW'(1);
              state_d     = S_COLLECT;
            end
          end
          S_COLLECT: begin
            rdy_c = !blocked_c;
            if (in_valid) begin
              if (blocked_c) begin
                state_d = S_FULL;
              end else if (last_c) begin
                dout_d = shadow_q;
`ifdef CM150_DEMUX_PARITY_EN
                frame_err_d = (^shadow_q) ^ bit_c;
`else
                dout_d[N-1] = bit_c;
`endif
                out_valid_d = 1'b1;
                chan_d      = '0;
                state_d     = S_IDLE;
              end else begin
                shadow_d[chan_q[SEL_W-1:0]] = bit_c;
                chan_d = chan_q + CW'(1);
              end
            end
          end
          S_FULL: begin
            if (out_ready) state_d = S_COLLECT;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
    in_ready = rdy_c & rst_n;
  end

  assign dout      = dout_q;
  assign out_valid = out_valid_q;
  assign wr_ack    = wr_ack_q;
  assign chan      = chan_q;
`ifdef CM150_DEMUX_PARITY_EN
  assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_cm150_demux.sv
// Bench for cm150_demux: directed scenarios plus a random phase, all checked
// against a frame-level reference model.
module tb_cm150_demux;

  localparam int unsigned SEL_W = 4;
  localparam int unsigned N     = 2**SEL_W;
`ifdef CM150_DEMUX_PARITY_EN
  localparam int unsigned FRAME = N + 1;
  localparam int unsigned CW    = SEL_W + 1;
`else
  localparam int unsigned FRAME = N;
  localparam int unsigned CW    = SEL_W;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             din_n = 1'b1;
  logic             dis = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [SEL_W-1:0] sel = '0;
  logic             mode_auto = 1'b0;
  logic             sync_clr = 1'b0;
  logic [N-1:0]     dout;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             wr_ack;
  logic [CW-1:0]    chan;
`ifdef CM150_DEMUX_PARITY_EN
  logic             frame_err;
`endif

  cm150_demux #(.SEL_W(SEL_W), .RST_WORD('0)) dut (
    .clk(clk), .rst_n(rst_n), .din_n(din_n), .dis(dis),
    .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .mode_auto(mode_auto), .sync_clr(sync_clr), .dout(dout),
    .out_valid(out_valid), .out_ready(out_ready), .wr_ack(wr_ack),
`ifdef CM150_DEMUX_PARITY_EN
    .frame_err(frame_err),
`endif
    .chan(chan)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ack_cnt = 0;

  // Reference model: frame-level view of the receiver.
  logic [N-1:0] m_dout;
  logic [N-1:0] m_bits;
  logic         m_ov;
  int           m_cnt;     // beats gathered in the current auto frame
  logic         m_stall;   // final beat waiting for the consumer
  logic         m_mode;    // mode as last seen by the receiver
  logic         m_ack;
  logic         m_err;
  logic         m_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dout = '0; m_bits = '0; m_ov = 1'b0; m_cnt = 0;
    m_stall = 1'b0; m_mode = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_acc = 1'b0;
  endtask

  function automatic logic model_ready();
    if (!rst_n || sync_clr) return 1'b0;
    if (dis) return 1'b1;
    if (mode_auto != m_mode) return 1'b0;
    if (!mode_auto) return 1'b1;
    if (m_stall) return 1'b0;
    if (m_cnt == FRAME - 1 && m_ov && !out_ready) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_advance(input logic rdy);
    logic b;
    b = ~din_n;
    m_acc = in_valid && rdy;
    m_ack = 1'b0;
    if (!rst_n) return;
    if (sync_clr || (!dis && mode_auto != m_mode)) begin
      m_cnt = 0; m_bits = '0; m_stall = 1'b0; m_mode = mode_auto;
    end else if (!dis) begin
      if (m_ov && out_ready) m_ov = 1'b0;
      if (!mode_auto) begin
        if (m_acc) begin m_dout[sel] = b; m_ack = 1'b1; end
      end else if (m_stall) begin
        if (out_ready) m_stall = 1'b0;
      end else if (m_acc) begin
        if (m_cnt < N) m_bits[m_cnt] = b;
        if (m_cnt == FRAME - 1) begin
          m_dout = m_bits;
          m_err  = (^m_bits) != b;
          m_ov   = 1'b1;
          m_cnt  = 0;
        end else begin
          m_cnt++;
        end
      end else if (in_valid && m_cnt == FRAME - 1 && m_ov && !out_ready) begin
        m_stall = 1'b1;
      end
    end
  endtask

  // One clock: check in_ready mid-cycle, advance model, check registered outputs.
  task automatic step();
    logic r;
    @(negedge clk);
    r = model_ready();
    chk("in_ready", 32'(in_ready), 32'(r));
    model_advance(r);
    @(posedge clk);
    #1;
    chk("dout", 32'(dout), 32'(m_dout));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("wr_ack", 32'(wr_ack), 32'(m_ack));
    chk("chan", 32'(chan), 32'(m_cnt));
`ifdef CM150_DEMUX_PARITY_EN
    if (m_ov) chk("frame_err", 32'(frame_err), 32'(m_err));
`endif
    if (wr_ack) ack_cnt++;
  endtask

  // Present beats first..last-1 of word w (beat N carries parity bit par).
  task automatic send_beats(input logic [N-1:0] w, input logic par, input int first, input int last);
    int k = first;
    int budget = 0;
    while (k < last && budget < 200) begin
      in_valid = 1'b1;
      din_n = (k < N) ? ~w[k] : ~par;
      step();
      if (m_acc) k++;
      budget++;
    end
    in_valid = 1'b0;
    if (k < last) chk("beat_budget", 32'(k), 32'(last));
  endtask

  task automatic send_frame(input logic [N-1:0] w);
    send_beats(w, ^w, 0, FRAME);
  endtask

  logic [N-1:0] w2;
  logic [N-1:0] w3;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_chan", 32'(chan), 32'h0);
    chk("rst_wr_ack", 32'(wr_ack), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    rst_n = 1'b1;

    // Addressed writes.
    ack_cnt = 0;
    in_valid = 1'b1;
    sel = SEL_W'(3);  din_n = 1'b0; step();
    sel = SEL_W'(15); din_n = 1'b0; step();
    sel = SEL_W'(3);  din_n = 1'b1; step();
    in_valid = 1'b0;
    step();
    chk("addr_dout", 32'(dout), 32'h8000);
    chk("addr_acks", 32'(ack_cnt), 32'd3);

    // Auto frame.
    mode_auto = 1'b1;
    step();
    send_frame(16'hA5C3);
    chk("auto_dout", 32'(dout), 32'hA5C3);
    chk("auto_valid", 32'(out_valid), 32'h1);
    chk("auto_chan", 32'(chan), 32'h0);

    // Backpressure: second frame stalls on its final beat.
    out_ready = 1'b0;
    w2 = N'($urandom);
    send_beats(w2, ^w2, 0, FRAME - 1);
    in_valid = 1'b1;
    din_n = (FRAME == N) ? ~w2[N-1] : ~(^w2);
    repeat (3) step();
    chk("bp_in_ready", 32'(in_ready), 32'h0);
    chk("bp_chan", 32'(chan), 32'(FRAME - 1));
    chk("bp_dout_held", 32'(dout), 32'hA5C3);
    out_ready = 1'b1;
    send_beats(w2, ^w2, FRAME - 1, FRAME);
    chk("bp_dout_new", 32'(dout), 32'(w2));
    chk("bp_valid", 32'(out_valid), 32'h1);
    step();
    chk("bp_consumed", 32'(out_valid), 32'h0);

    // Disable mid-frame, then synchronous clear.
    w3 = N'($urandom);
    send_beats(w3, ^w3, 0, 5);
    dis = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      din_n = 1'($urandom_range(0, 1));
      step();
    end
    dis = 1'b0;
    in_valid = 1'b0;
    chk("dis_chan", 32'(chan), 32'd5);
    send_beats(w3, ^w3, 5, 9);
    chk("pre_clr_chan", 32'(chan), 32'd9);
    sync_clr = 1'b1;
    in_valid = 1'b1;
    step();
    sync_clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_chan", 32'(chan), 32'h0);
    chk("clr_dout", 32'(dout), 32'(w2));

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      din_n     = 1'($urandom_range(0, 1));
      sel       = SEL_W'($urandom_range(0, N - 1));
      out_ready = ($urandom_range(0, 2) == 0);
      dis       = ($urandom_range(0, 19) == 0);
      sync_clr  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 59) == 0) mode_auto = ~mode_auto;
      step();
    end

    // Reset mid-frame.
    in_valid = 1'b0; dis = 1'b0; mode_auto = 1'b1; out_ready = 1'b1;
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    step();
    send_beats(w3, ^w3, 0, 7);
    chk("mid_chan", 32'(chan), 32'd7);
    rst_n = 1'b0;
    #1;
    chk("async_dout", 32'(dout), 32'h0);
    chk("async_valid", 32'(out_valid), 32'h0);
    chk("async_chan", 32'(chan), 32'h0);
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    send_frame(w3);
    chk("post_rst_dout", 32'(dout), 32'(w3));
    chk("post_rst_valid", 32'(out_valid), 32'h1);

`ifdef CM150_DEMUX_PARITY_EN
    // Parity: single set bit needs parity 1.
    send_beats(16'h0001, 1'b0, 0, FRAME);
    chk("par_err_set", 32'(frame_err), 32'h1);
    send_beats(16'h0001, 1'b1, 0, FRAME);
    chk("par_err_clr", 32'(frame_err), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cm150_demux.md
Name: cm150_demux

Overview:
- Receive-side counterpart of the 16:1 CM150 selector: takes the single active-low serial line the selector drives and rebuilds the 16 source bits into a registered parallel word.
- Two modes:
  - Addressed: each beat carries its 4-bit channel select.
  - Auto-sequence: an internal counter walks the channels 0..15.
- Completed frames are double-buffered and presented on a valid/ready output.
- Sits at the far end of a CM150 link in the mcnc91 test fabric.

Parameters:
- SEL_W, 4, select width; channel count N = 2**SEL_W (16 at default).
- RST_WORD, 0, reset value of dout and of the shadow buffer (N bits).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- din_n  in  1  serial data, active-low (line 0 = data 1), matching selector output polarity
- dis  in  1  disable, active-high; beats are consumed and discarded
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- sel  in  SEL_W  channel select for the beat (addressed mode only)
- mode_auto  in  1  1 = auto-sequence, 0 = addressed
- sync_clr  in  1  synchronous clear of the counter and shadow buffer
- dout  out  N  decoded parallel word
- out_valid  out  1  full frame available on dout (auto mode)
- out_ready  in  1  consumer accepts frame
- wr_ack  out  1  one-cycle pulse per addressed write
- chan  out  SEL_W  current auto counter value

Behaviour:
- Reset (rst_n=0, asynchronous): dout=RST_WORD, shadow=RST_WORD, chan=0, out_valid=0, wr_ack=0, state=IDLE. in_ready=0 while in reset.
- Beat acceptance: a beat is accepted when in_valid & in_ready. Decoded bit b = ~din_n.
- dis=1:
  - in_ready=1; accepted beats are dropped.
  - Counter, shadow, dout and out_valid hold; wr_ack=0.
  - dis has priority over everything except reset and sync_clr.
- Addressed mode (mode_auto=0):
  - Accepted beat sets dout[sel] <= b at the next edge; all other bits hold.
  - wr_ack=1 on the cycle after acceptance.
  - in_ready=1 always; out_valid is never set.
  - Latency from accept to dout update: 1 clock.
- Auto mode (mode_auto=1), states IDLE, COLLECT, FULL:
  - IDLE: chan=0. An accepted beat writes shadow[0] and moves to COLLECT with chan=1.
  - COLLECT: an accepted beat writes shadow[chan] and increments chan.
    - Beat at chan=N-1: copy shadow to dout (including the new bit), set out_valid=1, wrap chan to 0, go to IDLE.
    - If out_valid is still 1 and out_ready=0 at that point, go to FULL instead and do not accept the beat.
  - in_ready = !(state==COLLECT && chan==N-1 && out_valid && !out_ready). In FULL, in_ready=0.
  - FULL: when out_ready=1, out_valid clears; the next cycle returns to COLLECT at chan=N-1 with in_ready=1.
  - Frame handshake: out_valid falls on the edge where out_valid & out_ready, unless a new frame completes on that same edge; then out_valid stays 1 and dout takes the new word.
  - dout changes only on frame completion; bits 0..N-2 of a new frame never disturb the presented word.
- mode_auto change: on any cycle where mode_auto differs from its registered value:
  - chan=0, shadow=RST_WORD, state=IDLE.
  - A beat presented on that cycle is not accepted (in_ready=0 for that cycle).
  - dout and out_valid are untouched.
- sync_clr=1: chan=0, shadow=RST_WORD, state=IDLE and in_ready=0 for that cycle; dout and out_valid hold.
- Reset mid-frame: all state is lost, no partial frame is emitted, and out_valid drops asynchronously.
- Counter arithmetic: chan is modulo N and never exceeds N-1.

Optional Feature:
- Macro: CM150_DEMUX_PARITY_EN.
- Defined:
  - Auto frames are N+1 beats; beat N is even parity over the N data bits, decoded from din_n like a data bit.
  - Adds output frame_err (1 bit, reset 0), valid with out_valid: 1 when parity mismatches.
  - The frame is still delivered.
  - chan exposes the value N during the parity beat; SEL_W widens internally by 1.
- Not defined: N-beat frames, no frame_err port.

Test Plan:
- Reset: assert rst_n=0 mid-COLLECT at chan=7 -> dout=0, out_valid=0 and chan=0 immediately; a fresh frame afterwards completes normally.
- Addressed: mode_auto=0, beats (sel=3, din_n=0), (sel=15, din_n=0), (sel=3, din_n=1) -> dout=16'h8000 after the third; wr_ack pulses 3 times.
- Auto frame: 16 beats with din_n = ~16'hA5C3 bit-by-bit, LSB first -> dout=16'hA5C3, out_valid=1 exactly 1 cycle after beat 15; chan back to 0.
- Backpressure: out_ready=0, second frame streamed -> in_ready=0 at chan=15 (FULL); raise out_ready -> first word consumed, beat 15 accepted, dout = second word.
- Disable/clear: dis=1 for 5 beats mid-frame -> chan unchanged. sync_clr at chan=9 -> chan=0 and the previous dout retained.
- Parity (CM150_DEMUX_PARITY_EN): frame 16'h0001 with parity bit 0 -> frame_err=1; with parity bit 1 -> frame_err=0.
